// File: rtl/alu_op_ctrl.sv
// Issue/capture sequencer in front of the 9:1 ALU result mux: latches one operation,
// waits LAT settle cycles, captures the mux output and hands it downstream.
module alu_op_ctrl #(
    parameter int WIDTH = 8,
    parameter int LAT   = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [3:0]       op_code,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] dp_a,
    output logic [WIDTH-1:0] dp_b,
    output logic [3:0]       mux_sel,
    input  logic [WIDTH-1:0] mux_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             res_err,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HOLD
    } state_t;

    localparam logic [3:0] LAST_OP = 4'd8;
    localparam logic [3:0] LAT_V   = 4'(LAT);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] dp_a_d, dp_b_d, result_d;
    logic [3:0]       mux_sel_d;
    logic             res_err_d, op_ready_d, res_valid_d;
    logic [CNT_W-1:0] op_count_d;

    // NOTE: every variable gets its hold value first, so no path through the case
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dp_a_d     = dp_a;
        dp_b_d     = dp_b;
        mux_sel_d  = mux_sel;
        result_d   = result;
        res_err_d  = res_err;
        op_count_d = op_count;

        unique case (state_q)
            IDLE: begin
                if (op_valid && op_ready) begin
                    if (op_code <= LAST_OP) begin
                        dp_a_d    = operand_a;
                        dp_b_d    = operand_b;
                        mux_sel_d = op_code;
                        cnt_d     = LAT_V;
                        state_d   = WAIT;
                    end else begin
                        // Illegal opcodes never reach the datapath; the select keeps its last value.
                        result_d  = '0;
                        res_err_d = 1'b1;
                        state_d   = HOLD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    result_d  = mux_result;
                    res_err_d = 1'b0;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    op_count_d = op_count + CNT_W'(1);
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake flags are decoded from the next state so they come straight off flops.
        op_ready_d  = (state_d == IDLE);
        res_valid_d = (state_d == HOLD);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dp_a      <= '0;
            dp_b      <= '0;
            mux_sel   <= '0;
            result    <= '0;
            res_err   <= 1'b0;
            op_count  <= '0;
            op_ready  <= 1'b1;
            res_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dp_a      <= dp_a_d;
            dp_b      <= dp_b_d;
            mux_sel   <= mux_sel_d;
            result    <= result_d;
            res_err   <= res_err_d;
            op_count  <= op_count_d;
            op_ready  <= op_ready_d;
            res_valid <= res_valid_d;
        end
    end

endmodule

// File: tb/tb_alu_op_ctrl.sv
// Bench for alu_op_ctrl: a timestamp-based transaction model checked every cycle,
// plus directed vectors with literal expectations; a LAT=0/CNT_W=4 build covers wrap.
module tb_alu_op_ctrl;

    localparam int LAT = 2;

    logic        clk;
    logic        rst_n;
    logic        op_valid, op_ready, res_valid, res_ready, res_err;
    logic [3:0]  op_code, mux_sel;
    logic [7:0]  operand_a, operand_b, dp_a, dp_b, mux_result, result;
    logic [15:0] op_count;

    logic        s_op_valid, s_op_ready, s_res_valid, s_res_ready, s_res_err;
    logic [3:0]  s_op_code, s_mux_sel, s_op_count;
    logic [7:0]  s_dp_a, s_dp_b, s_mux_result, s_result;

    int total = 0;
    int bad   = 0;

    // Hand-computed results for a=8'h5A, b=8'h0F, indexed by opcode.
    logic [7:0] exp_tab [9] = '{8'h0A, 8'h5F, 8'h55, 8'h69, 8'h4B, 8'h5A, 8'h0F, 8'hA5, 8'hB4};

    alu_op_ctrl #(.WIDTH(8), .LAT(LAT), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .operand_a(operand_a), .operand_b(operand_b),
        .dp_a(dp_a), .dp_b(dp_b), .mux_sel(mux_sel), .mux_result(mux_result),
        .res_valid(res_valid), .res_ready(res_ready), .result(result),
        .res_err(res_err), .op_count(op_count)
    );

    alu_op_ctrl #(.WIDTH(8), .LAT(0), .CNT_W(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .op_valid(s_op_valid), .op_ready(s_op_ready),
        .op_code(s_op_code), .operand_a(operand_a), .operand_b(operand_b),
        .dp_a(s_dp_a), .dp_b(s_dp_b), .mux_sel(s_mux_sel), .mux_result(s_mux_result),
        .res_valid(s_res_valid), .res_ready(s_res_ready), .result(s_result),
        .res_err(s_res_err), .op_count(s_op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a ^ b;
            4'd3:    return a + b;
            4'd4:    return a - b;
            4'd5:    return a;
            4'd6:    return b;
            4'd7:    return ~a;
            4'd8:    return a << 1;
            default: return 8'hEE;
        endcase
    endfunction

    // Stand-in datapath: the 9:1 mux driven by whatever the DUT selects.
    always_comb begin
        mux_result   = alu(mux_sel, dp_a, dp_b);
        s_mux_result = alu(s_mux_sel, s_dp_a, s_dp_b);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid();
        for (int n = 0; n < 20 && !res_valid; n++) tick();
        check("res_valid_timeout", {31'd0, res_valid}, 32'd1);
    endtask

    // Transaction model: each accepted op has a due edge after which its result is visible.
    int          m_cyc    = 0;
    bit          m_busy   = 0;
    int          m_due    = 0;
    logic [7:0]  m_pend   = '0;
    logic [7:0]  m_result = '0;
    bit          m_err    = 0;
    logic [15:0] m_count  = '0;
    logic [7:0]  m_a = '0, m_b = '0;
    logic [3:0]  m_sel = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc = 0; m_busy = 0; m_due = 0; m_pend = '0; m_result = '0;
            m_err = 0; m_count = '0; m_a = '0; m_b = '0; m_sel = '0;
        end else begin
            m_cyc++;
            if (!m_busy) begin
                if (op_valid) begin
                    m_busy = 1;
                    if (op_code <= 4'd8) begin
                        m_due  = m_cyc + LAT + 1;
                        m_pend = alu(op_code, operand_a, operand_b);
                        m_a    = operand_a;
                        m_b    = operand_b;
                        m_sel  = op_code;
                    end else begin
                        m_due    = m_cyc;
                        m_result = '0;
                        m_err    = 1;
                    end
                end
            end else if (m_cyc > m_due) begin
                if (res_ready) begin
                    m_busy = 0;
                    m_count++;
                end
            end else if (m_cyc == m_due) begin
                m_result = m_pend;
                m_err    = 0;
            end
        end
    end

    always @(negedge clk) begin
        check("cmp_op_ready", {31'd0, op_ready}, {31'd0, !m_busy});
        check("cmp_res_valid", {31'd0, res_valid}, {31'd0, m_busy && m_cyc >= m_due});
        check("cmp_result", {24'd0, result}, {24'd0, m_result});
        check("cmp_res_err", {31'd0, res_err}, {31'd0, m_err});
        check("cmp_op_count", {16'd0, op_count}, {16'd0, m_count});
        check("cmp_dp_a", {24'd0, dp_a}, {24'd0, m_a});
        check("cmp_dp_b", {24'd0, dp_b}, {24'd0, m_b});
        check("cmp_mux_sel", {28'd0, mux_sel}, {28'd0, m_sel});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        rst_n = 1'b0; op_valid = 1'b0; op_code = '0; res_ready = 1'b0;
        operand_a = 8'h5A; operand_b = 8'h0F;
        s_op_valid = 1'b0; s_op_code = '0; s_res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_op_ready", {31'd0, op_ready}, 32'd1);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_result", {24'd0, result}, 32'd0);
        check("rst_op_count", {16'd0, op_count}, 32'd0);
        check("rst_mux_sel", {28'd0, mux_sel}, 32'd0);

        // Reset in the middle of WAIT abandons the op.
        op_code = 4'd2; op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        tick();
        check("midwait_op_ready", {31'd0, op_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_op_ready", {31'd0, op_ready}, 32'd1);
        check("midrst_res_valid", {31'd0, res_valid}, 32'd0);
        check("midrst_result", {24'd0, result}, 32'd0);
        check("midrst_op_count", {16'd0, op_count}, 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("no_res_after_rst", {31'd0, res_valid}, 32'd0);
        end

        // Sweep every legal select with res_ready tied high.
        res_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            op_code = 4'(i); op_valid = 1'b1;
            tick();
            op_valid = 1'b0;
            check("sweep_sel", {28'd0, mux_sel}, i);
            wait_valid();
            check("sweep_result", {24'd0, result}, {24'd0, exp_tab[i]});
            check("sweep_err", {31'd0, res_err}, 32'd0);
            tick();
        end
        check("sweep_count", {16'd0, op_count}, 32'd9);

        // Exact LAT=2 timing, then backpressure in HOLD.
        res_ready = 1'b0;
        op_code = 4'd3; op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        check("lat_sel", {28'd0, mux_sel}, 32'd3);
        check("lat_valid_k", {31'd0, res_valid}, 32'd0);
        tick();
        check("lat_valid_k1", {31'd0, res_valid}, 32'd0);
        tick();
        check("lat_valid_k2", {31'd0, res_valid}, 32'd0);
        tick();
        check("lat_valid_k3", {31'd0, res_valid}, 32'd1);
        check("lat_result", {24'd0, result}, 32'h69);
        check("lat_err", {31'd0, res_err}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            op_valid = (i % 2 == 0);
            op_code  = 4'd5;
            tick();
            check("bp_result", {24'd0, result}, 32'h69);
            check("bp_valid", {31'd0, res_valid}, 32'd1);
            check("bp_op_ready", {31'd0, op_ready}, 32'd0);
            check("bp_sel", {28'd0, mux_sel}, 32'd3);
        end
        op_valid = 1'b0;
        res_ready = 1'b1;
        tick();
        check("bp_handoff_valid", {31'd0, res_valid}, 32'd0);
        check("bp_handoff_ready", {31'd0, op_ready}, 32'd1);
        check("bp_handoff_count", {16'd0, op_count}, 32'd10);

        // Illegal opcodes skip the datapath and flag an error.
        for (int i = 0; i < 2; i++) begin
            op_code = (i == 0) ? 4'd9 : 4'd15; op_valid = 1'b1;
            tick();
            op_valid = 1'b0;
            check("ill_valid", {31'd0, res_valid}, 32'd1);
            check("ill_result", {24'd0, result}, 32'd0);
            check("ill_err", {31'd0, res_err}, 32'd1);
            check("ill_sel", {28'd0, mux_sel}, 32'd3);
            check("ill_dp_a", {24'd0, dp_a}, 32'h5A);
            tick();
            check("ill_handoff", {31'd0, res_valid}, 32'd0);
        end
        check("ill_count", {16'd0, op_count}, 32'd12);

        // A legal op after an illegal one clears the error flag.
        op_code = 4'd7; op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        wait_valid();
        check("post_ill_result", {24'd0, result}, 32'hA5);
        check("post_ill_err", {31'd0, res_err}, 32'd0);
        tick();
        check("post_ill_count", {16'd0, op_count}, 32'd13);

        // LAT=0, CNT_W=4 build: one-edge capture and counter wrap after 16 ops.
        s_res_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            s_op_code = 4'(i % 9); s_op_valid = 1'b1;
            tick();
            s_op_valid = 1'b0;
            check("lat0_valid_k", {31'd0, s_res_valid}, 32'd0);
            tick();
            check("lat0_valid_k1", {31'd0, s_res_valid}, 32'd1);
            check("lat0_result", {24'd0, s_result}, {24'd0, exp_tab[i % 9]});
            tick();
            check("wrap_count", {28'd0, s_op_count}, (i + 1) % 16);
        end
        check("wrap_zero", {28'd0, s_op_count}, 32'd0);

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
